uart_tx_8n1: RTL and testbench
==============================

# uart_tx_8n1

Standalone UART serial transmitter: accepts a parallel byte with a one-cycle start strobe and shifts it out LSB-first as an 8N1-style frame on a single line, timed by a 16x-oversampling baud tick. It is the transmit end paired with the existing UART receiver in `uart_top`. It drives the receiver's serial input in loopback benches and the external TX pin in the final design.

## Interface
- `DATA_BITS`, default 8: payload bits per frame (7 or 8).
- `STOP_TICKS`, default 16: oversample ticks in the stop bit (16 = 1, 24 = 1.5, 32 = 2 stop bits).
- `BAUD_DIV`, default 1: clocks per oversample tick. With a 16 kHz clock, 1 gives 1000 baud.

Ports:
- `clk`  input  1  system clock. Single clock domain.
- `reset`  input  1  asynchronous, active-high reset.
- `tx_start`  input  1  transmit request, sampled on `clk` rising edge.
- `tx_data`  input  DATA_BITS  payload, captured when `tx_start` is accepted.
- `tx`  output  1  serial line, idle high, registered.
- `tx_busy`  output  1  high from acceptance until the frame completes.
- `tx_done_tick`  output  1  one-cycle pulse at frame completion.

## Operation
- FSM has four states.
  - IDLE: `tx`=1. On `tx_start`=1: latch `tx_data` into the shift register, clear the tick counter, restart the baud divider, and go to START.
  - START: `tx`=0 for 16 ticks, then go to DATA with bit index 0.
  - DATA: `tx`=shreg[0] for 16 ticks per bit, then shift right. After DATA_BITS bits, go to STOP.
  - STOP: `tx`=1 for STOP_TICKS ticks, then go to IDLE and pulse `tx_done_tick`.
- `tx_start` is ignored in every state except IDLE. `tx_data` changes after acceptance do not affect the frame in flight.
- Tick counter is 5 bits, enough for STOP_TICKS up to 32. Bit index is 3 bits.
- Baud divider counts 0..BAUD_DIV-1 and asserts a tick at terminal count. With BAUD_DIV=1, a tick occurs every cycle.
- `tx_busy` = (state != IDLE).
- Reset values: state IDLE, `tx`=1, `tx_busy`=0, `tx_done_tick`=0, counters 0, shift register 0.
- Reset mid-frame: the frame is aborted immediately and `tx` returns high asynchronously. No done pulse is produced.

## Timing
- Acceptance edge is edge N. `tx` falls and `tx_busy` rises after edge N, with no cycle of idle delay.
- Each start or data bit lasts exactly 16*BAUD_DIV cycles. The stop bit lasts STOP_TICKS*BAUD_DIV cycles.
- Frame length = (16*(1+DATA_BITS) + STOP_TICKS)*BAUD_DIV cycles. Defaults give 160 cycles.
- `tx_done_tick` is high for exactly the one cycle after the final stop tick. In that same cycle, state is IDLE and `tx_busy`=0.
- Back-to-back: if `tx_start` is high in the done cycle, it is accepted at the next edge. The minimum inter-frame gap is one cycle of `tx`=1 beyond the stop bit.
- `tx_start` held high continuously produces consecutive frames separated by that one-cycle gap. Each frame captures `tx_data` at its own acceptance.

## Structure
- Shared package `uart_pkg` holds:
  - state typedef/localparams IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - `OVERSAMPLE`=16;
  - the default STOP_TICKS.
- The receiver uses the same package.
- One sub-module: `uart_baud_gen`, a parameterised tick divider with a synchronous restart input. The receiver reuses it.
- The remainder is a single FSM-plus-datapath module.

## Test plan
- Reset behaviour: assert `reset` with no clock edges. Required: `tx`=1, `tx_busy`=0, `tx_done_tick`=0.
- Single frame at defaults: `tx_data`=8'hA5 with a 1-cycle `tx_start`.
  - `tx` sequence, 16 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 1.
  - `tx_done_tick` pulses once, 160 cycles after acceptance.
- Start while busy: send 8'h3C, then pulse `tx_start` with 8'hFF at cycle 50. Required: the second request is ignored, the 8'h3C frame is unchanged, and only one done pulse occurs.
- Back-to-back: hold `tx_start` high with 8'h55 then 8'h0F. Required:
  - two correct frames;
  - the second start bit begins exactly 1 cycle after the first done pulse.
- Reset mid-frame: assert `reset` at cycle 70 of a frame. Required:
  - `tx`=1 immediately, with no done pulse;
  - the next 8'h81 frame after release is correct.
- Loopback and parameter variation: connect `tx` to the existing receiver and send 8'b10101010. Required: receiver `rx_data`=8'b10101010 on its done tick.
  - Repeat with BAUD_DIV=4 and STOP_TICKS=32: the frame is 704 cycles long.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM state
// encoding, oversampling ratio and counter widths.
package uart_pkg;

    // Frame FSM states, shared by transmitter and receiver.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Oversample ticks per start/data bit.
    localparam int OVERSAMPLE = 16;

    // Default stop-bit length in oversample ticks (one stop bit).
    localparam int STOP_TICKS_DEFAULT = 16;

    // Tick counter must hold STOP_TICKS-1 for up to two stop bits (32 ticks).
    localparam int TICK_CNT_W = 5;

    // Bit index covers up to eight payload bits.
    localparam int BIT_IDX_W = 3;

    // Whole-frame length in clock cycles, handy for benches and timeouts.
    function automatic int frame_cycles(input int data_bits,
                                        input int stop_ticks,
                                        input int baud_div);
        return (OVERSAMPLE * (1 + data_bits) + stop_ticks) * baud_div;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick divider: pulses tick once every DIV clocks. A synchronous
// restart realigns the phase so the first tick lands DIV clocks after it.
module uart_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    // A one-bit counter is kept even for DIV=1 so widths stay legal.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at terminal count, zero on restart.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || (cnt_q == TERM)) begin
            cnt_d = '0;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TERM);

endmodule

// File: rtl/uart_tx_8n1.sv
// UART transmitter: start bit, DATA_BITS payload bits LSB first, then a stop
// period of STOP_TICKS oversample ticks. The line output is registered so the
// start bit appears on the acceptance edge itself.
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_TICKS = STOP_TICKS_DEFAULT,
    parameter int BAUD_DIV   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    localparam logic [TICK_CNT_W-1:0] LAST_OS   = TICK_CNT_W'(OVERSAMPLE - 1);
    localparam logic [TICK_CNT_W-1:0] LAST_STOP = TICK_CNT_W'(STOP_TICKS - 1);
    localparam logic [BIT_IDX_W-1:0]  LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_e            state_q;
    logic [TICK_CNT_W-1:0]  tick_cnt_q;
    logic [BIT_IDX_W-1:0]   bit_idx_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   tx_q;
    logic                   done_q;

    logic baud_tick;
    logic baud_restart;

    // Hold the divider at phase zero while idle so every frame starts with a
    // full-length first tick period, whatever the idle time was.
    assign baud_restart = (state_q == IDLE);

    uart_baud_gen #(
        .DIV(BAUD_DIV)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(baud_restart),
        .tick   (baud_tick)
    );

    // Frame sequencer with registered line and done outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_start) begin
                        shreg_q    <= tx_data;
                        tick_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tick_cnt_q == LAST_OS) begin
                            tick_cnt_q <= '0;
                            bit_idx_q  <= '0;
                            tx_q       <= shreg_q[0];
                            state_q    <= DATA;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (tick_cnt_q == LAST_OS) begin
                            tick_cnt_q <= '0;
                            if (bit_idx_q == LAST_BIT) begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end else begin
                                // Present the next bit now; the shift keeps
                                // shreg_q[0] equal to the bit on the line.
                                shreg_q   <= shreg_q >> 1;
                                tx_q      <= shreg_q[1];
                                bit_idx_q <= bit_idx_q + 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (tick_cnt_q == LAST_STOP) begin
                            tick_cnt_q <= '0;
                            done_q     <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1: two instances (defaults, and BAUD_DIV=4 with two
// stop bits). Stimulus queues expected bytes; a monitor decodes each frame
// from the line and checks waveform, data and done timing against them.
module tb_uart_tx_8n1;

    localparam int D_A  = 1;
    localparam int ST_A = 16;
    localparam int D_B  = 4;
    localparam int ST_B = 32;

    logic clk;
    logic reset;
    logic start_a, start_b;
    logic [7:0] data_a, data_b;
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;

    uart_tx_8n1 #(.DATA_BITS(8), .STOP_TICKS(ST_A), .BAUD_DIV(D_A)) dut_a (
        .clk(clk), .reset(reset), .tx_start(start_a), .tx_data(data_a),
        .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a)
    );

    uart_tx_8n1 #(.DATA_BITS(8), .STOP_TICKS(ST_B), .BAUD_DIV(D_B)) dut_b (
        .clk(clk), .reset(reset), .tx_start(start_b), .tx_data(data_b),
        .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int check_cnt = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    logic [1:0] tx_w, done_w, busy_w;
    assign tx_w   = {tx_b, tx_a};
    assign done_w = {done_b, done_a};
    assign busy_w = {busy_b, busy_a};

    int         cyc;
    logic       active [2];
    int         start_cyc [2];
    int         last_done [2];
    int         gap [2];
    int         bad_off [2];
    logic [7:0] exp_byte [2];
    logic [7:0] rx_byte [2];
    int         done_cnt [2];
    int         fin [2];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected line level at offset o (cycles after acceptance) of a frame.
    function automatic logic exp_bit(input int o, input int d, input logic [7:0] b);
        int bp;
        bp = o / (16 * d);
        if (bp == 0) return 1'b0;
        if (bp <= 8) return b[bp-1];
        return 1'b1;
    endfunction

    // Monitor: frame decoder and scoreboard for both instances.
    int m_d, m_len, m_o, m_bp;
    initial begin
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            active[i] = 1'b0; start_cyc[i] = 0; last_done[i] = -1000;
            gap[i] = 0; bad_off[i] = -1; exp_byte[i] = '0; rx_byte[i] = '0;
            done_cnt[i] = 0; fin[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                m_d   = (i == 0) ? D_A : D_B;
                m_len = (16 * 9 + ((i == 0) ? ST_A : ST_B)) * m_d;
                if (done_w[i] === 1'b1) done_cnt[i]++;
                if (reset) begin
                    active[i] = 1'b0;
                end else if (!active[i] && tx_w[i] === 1'b0) begin
                    active[i]    = 1'b1;
                    start_cyc[i] = cyc;
                    gap[i]       = cyc - last_done[i];
                    bad_off[i]   = -1;
                    rx_byte[i]   = '0;
                    if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
                        check($sformatf("unexpected_frame_%0d", i), 32'd1, 32'd0);
                        exp_byte[i] = '0;
                    end else if (i == 0) begin
                        exp_byte[i] = q_a.pop_front();
                    end else begin
                        exp_byte[i] = q_b.pop_front();
                    end
                end
                if (active[i] && !reset) begin
                    m_o = cyc - start_cyc[i];
                    if (m_o < m_len) begin
                        if ((tx_w[i] !== exp_bit(m_o, m_d, exp_byte[i]) ||
                             busy_w[i] !== 1'b1 || done_w[i] !== 1'b0) && bad_off[i] < 0)
                            bad_off[i] = m_o;
                        m_bp = m_o / (16 * m_d);
                        if ((m_o % (16 * m_d)) == 8 * m_d && m_bp >= 1 && m_bp <= 8)
                            rx_byte[i][m_bp-1] = tx_w[i];
                    end else begin
                        $display("frame dut%0d: expected 0x%02h decoded 0x%02h first_bad_offset %0d",
                                 i, exp_byte[i], rx_byte[i], bad_off[i]);
                        check($sformatf("frame_wave_dut%0d_first_bad_offset", i),
                              32'(bad_off[i]), 32'hFFFF_FFFF);
                        check($sformatf("rx_data_dut%0d", i), {24'd0, rx_byte[i]},
                              {24'd0, exp_byte[i]});
                        check($sformatf("done_slot_dut%0d_{done,busy,tx}", i),
                              {29'd0, done_w[i], busy_w[i], tx_w[i]}, 32'b101);
                        active[i]    = 1'b0;
                        last_done[i] = cyc;
                        fin[i]++;
                    end
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] b);
        @(negedge clk);
        if (i == 0) begin data_a = b; start_a = 1'b1; q_a.push_back(b); end
        else        begin data_b = b; start_b = 1'b1; q_b.push_back(b); end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_fin(input int i, input int target, input int budget);
        int n;
        n = 0;
        while (fin[i] < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (fin[i] < target) check($sformatf("timeout_frames_dut%0d", i), 32'(fin[i]), 32'(target));
    endtask

    int f0, dc0;

    initial begin
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
        // Reset with no clock edge yet: outputs must settle asynchronously.
        #2 reset = 1'b1;
        #1;
        check("reset_tx", {31'd0, tx_a}, 32'd1);
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_done", {31'd0, done_a}, 32'd0);
        check("reset_tx_b", {31'd0, tx_b}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single frame at defaults.
        send(0, 8'hA5);
        wait_fin(0, 1, 400);

        // Start request while busy must be ignored.
        f0 = fin[0]; dc0 = done_cnt[0];
        send(0, 8'h3C);
        repeat (49) @(negedge clk);
        data_a = 8'hFF; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; data_a = 8'h00;
        wait_fin(0, f0 + 1, 400);
        repeat (200) @(negedge clk);
        check("busy_ignore_frames", 32'(fin[0]), 32'(f0 + 1));
        check("busy_ignore_done_pulses", 32'(done_cnt[0]), 32'(dc0 + 1));

        // Back-to-back with tx_start held high.
        f0 = fin[0];
        @(negedge clk);
        data_a = 8'h55; start_a = 1'b1; q_a.push_back(8'h55); q_a.push_back(8'h0F);
        @(posedge clk);
        #1 data_a = 8'h0F;
        wait_fin(0, f0 + 1, 400);
        #1 start_a = 1'b0;
        wait_fin(0, f0 + 2, 400);
        check("b2b_gap_cycles", 32'(gap[0]), 32'd1);

        // Reset at cycle 70 of a frame.
        repeat (5) @(negedge clk);
        f0 = fin[0]; dc0 = done_cnt[0];
        send(0, 8'hC3);
        repeat (69) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_tx", {31'd0, tx_a}, 32'd1);
        check("midreset_busy", {31'd0, busy_a}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("midreset_no_done", 32'(done_cnt[0]), 32'(dc0));
        send(0, 8'h81);
        wait_fin(0, f0 + 1, 400);

        // Loopback decode at both parameter sets.
        send(0, 8'b1010_1010);
        wait_fin(0, f0 + 2, 400);
        send(1, 8'b1010_1010);
        wait_fin(1, 1, 2000);
        check("dut1_done_pulses", 32'(done_cnt[1]), 32'd1);
        check("leftover_expected_a", 32'(q_a.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
